// File: rtl/sim_run_controller_pkg.sv
// Shared definitions for the simulation run controller: run-state encoding
// and the default bus width / tohost address used by the sim tops.
package sim_run_controller_pkg;

    localparam int          DEFAULT_WIDTH       = 32;
    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_3FFC;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } run_state_t;

endpackage

// File: rtl/sim_run_controller_if.sv
// Per-hart data-memory bus as seen by the run controller. The CPUs (or a
// testbench) drive it through the master modport; the controller only snoops.
interface sim_run_controller_if
    import sim_run_controller_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int NUM_HARTS = 1
) ();

    logic [NUM_HARTS-1:0]       mem_write_en;
    logic [NUM_HARTS*WIDTH-1:0] addr_bus;
    logic [NUM_HARTS*WIDTH-1:0] data_bus_out;

    modport master (
        output mem_write_en,
        output addr_bus,
        output data_bus_out
    );

    modport slave (
        input mem_write_en,
        input addr_bus,
        input data_bus_out
    );

endinterface

// File: rtl/sim_run_controller_hart_halt_tracker.sv
// One hart's halt tracker: spots a store to the tohost address while the run
// is active, keeps a sticky halt flag and a saturating count of the cycles
// the hart ran before that store.
module sim_run_controller_hart_halt_tracker
    import sim_run_controller_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TOHOST_ADDR = WIDTH'(DEFAULT_TOHOST_ADDR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_run,
    input  logic             i_mem_write_en,
    input  logic [WIDTH-1:0] i_addr,
    output logic             o_hit,
    output logic             o_halted,
    output logic [WIDTH-1:0] o_cycles
);

    logic             r_halted;
    logic [WIDTH-1:0] r_cycles;
    logic             w_hit;

    // A halt event is the first tohost store seen during RUN; later ones are ignored.
    assign w_hit = i_run && i_mem_write_en && (i_addr == TOHOST_ADDR) && !r_halted;

    // Sticky halt flag and cycle counter; the halting cycle itself is not counted.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst || i_clear) begin
            r_halted <= 1'b0;
            r_cycles <= '0;
        end else if (w_hit) begin
            r_halted <= 1'b1;
        end else if (i_run && !r_halted && (r_cycles != '1)) begin
            r_cycles <= r_cycles + WIDTH'(1);
        end
    end

    assign o_hit    = w_hit;
    assign o_halted = r_halted;
    assign o_cycles = r_cycles;

endmodule

// File: rtl/sim_run_controller.sv
// Run controller for CPU simulation tops: sequences the core reset pulse,
// runs until every hart has stored to tohost (then drains) or the cycle limit
// expires, and holds exit code, per-hart and total cycle counts in DONE.
module sim_run_controller
    import sim_run_controller_pkg::*;
#(
    parameter int               WIDTH        = DEFAULT_WIDTH,
    parameter int               NUM_HARTS    = 1,
    parameter int               RESET_CYCLES = 2,
    parameter int               MAX_CYCLES   = 1000,
    parameter int               DRAIN_CYCLES = 4,
    parameter logic [WIDTH-1:0] TOHOST_ADDR  = WIDTH'(DEFAULT_TOHOST_ADDR)
) (
    input  logic                       InputClk,
    input  logic                       rst,
    input  logic                       start,
    sim_run_controller_if.slave        bus,
    output logic                       core_rst,
    output logic                       running,
    output logic                       done,
    output logic                       timeout,
    output logic [NUM_HARTS-1:0]       halted,
    output logic [WIDTH-1:0]           exit_code,
    output logic [NUM_HARTS*WIDTH-1:0] hart_cycles,
    output logic [WIDTH-1:0]           total_cycles
);

    // Down-counter reload values and the last RUN cycle before timeout.
    // RESET_CYCLES and DRAIN_CYCLES are expected to be at least 1.
    localparam logic [WIDTH-1:0] RESET_LOAD = WIDTH'(RESET_CYCLES - 1);
    localparam logic [WIDTH-1:0] DRAIN_LOAD = WIDTH'(DRAIN_CYCLES - 1);
    localparam logic [WIDTH-1:0] MAX_LAST   = WIDTH'(MAX_CYCLES - 1);

    run_state_t       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_total;
    logic [WIDTH-1:0] r_exit_code;
    logic             r_core_rst;
    logic             r_running;
    logic             r_done;
    logic             r_timeout;

    logic [NUM_HARTS-1:0] w_hit;
    logic [NUM_HARTS-1:0] w_halted;
    logic                 w_start_run;
    logic                 w_in_run;
    logic                 w_all_halted_next;
    logic                 w_first_halt;
    logic [WIDTH-1:0]     w_first_data;

    assign w_start_run       = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_in_run          = (r_state == ST_RUN);
    assign w_all_halted_next = &(w_halted | w_hit);

    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
        sim_run_controller_hart_halt_tracker #(
            .WIDTH       (WIDTH),
            .TOHOST_ADDR (TOHOST_ADDR)
        ) u_tracker (
            .clk            (InputClk),
            .rst            (rst),
            .i_clear        (w_start_run),
            .i_run          (w_in_run),
            .i_mem_write_en (bus.mem_write_en[g]),
            .i_addr         (bus.addr_bus[g*WIDTH +: WIDTH]),
            .o_hit          (w_hit[g]),
            .o_halted       (w_halted[g]),
            .o_cycles       (hart_cycles[g*WIDTH +: WIDTH])
        );
    end

    // Pick the exit code of the first halt; scanning downwards lets the lowest hart win a tie.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_first_halt = 1'b0;
        w_first_data = '0;
        for (int i = NUM_HARTS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_first_halt = 1'b1;
                w_first_data = bus.data_bus_out[i*WIDTH +: WIDTH];
            end
        end
        w_first_halt = w_first_halt && !(|w_halted);
    end

    // Run FSM with registered status outputs, shared reset/drain down-counter and total counter.
    always_ff @(posedge InputClk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_total     <= '0;
            r_exit_code <= '0;
            r_core_rst  <= 1'b1;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_RESET;
                        r_cnt       <= RESET_LOAD;
                        r_total     <= '0;
                        r_exit_code <= '0;
                        r_core_rst  <= 1'b1;
                        r_running   <= 1'b0;
                        r_done      <= 1'b0;
                        r_timeout   <= 1'b0;
                    end
                end
                ST_RESET: begin
                    if (r_cnt == '0) begin
                        r_state    <= ST_RUN;
                        r_core_rst <= 1'b0;
                        r_running  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    if (r_total != '1) begin
                        r_total <= r_total + WIDTH'(1);
                    end
                    if (w_first_halt) begin
                        r_exit_code <= w_first_data;
                    end
                    // A final halt on the limit edge takes priority over the timeout.
                    if (w_all_halted_next) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= DRAIN_LOAD;
                    end else if (r_total == MAX_LAST) begin
                        r_state    <= ST_DONE;
                        r_timeout  <= 1'b1;
                        r_core_rst <= 1'b1;
                        r_running  <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state    <= ST_DONE;
                        r_core_rst <= 1'b1;
                        r_running  <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_rst     = r_core_rst;
    assign running      = r_running;
    assign done         = r_done;
    assign timeout      = r_timeout;
    assign halted       = w_halted;
    assign exit_code    = r_exit_code;
    assign total_cycles = r_total;

endmodule

// File: tb/tb_sim_run_controller.sv
// Self-checking bench for sim_run_controller (2 harts, 50-cycle limit).
// Each run is described by the cycle on which every hart first stores to
// tohost (or never); the expected results are derived from those halt times.
module tb_sim_run_controller;

    localparam int               WIDTH        = 32;
    localparam int               NUM_HARTS    = 2;
    localparam int               RESET_CYCLES = 2;
    localparam int               MAX_CYCLES   = 50;
    localparam int               DRAIN_CYCLES = 4;
    localparam logic [WIDTH-1:0] TOHOST       = 32'h0000_3FFC;
    localparam int               NEVER        = 1000;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic                       core_rst;
    logic                       running;
    logic                       done;
    logic                       timeout;
    logic [NUM_HARTS-1:0]       halted;
    logic [WIDTH-1:0]           exit_code;
    logic [NUM_HARTS*WIDTH-1:0] hart_cycles;
    logic [WIDTH-1:0]           total_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sim_run_controller_if #(.WIDTH(WIDTH), .NUM_HARTS(NUM_HARTS)) bus_if ();

    sim_run_controller #(
        .WIDTH        (WIDTH),
        .NUM_HARTS    (NUM_HARTS),
        .RESET_CYCLES (RESET_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .TOHOST_ADDR  (TOHOST)
    ) u_dut (
        .InputClk     (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus_if.slave),
        .core_rst     (core_rst),
        .running      (running),
        .done         (done),
        .timeout      (timeout),
        .halted       (halted),
        .exit_code    (exit_code),
        .hart_cycles  (hart_cycles),
        .total_cycles (total_cycles)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_hart(input int i, input logic we, input logic [WIDTH-1:0] addr,
                              input logic [WIDTH-1:0] data);
        bus_if.mem_write_en[i]                 = we;
        bus_if.addr_bus[i*WIDTH +: WIDTH]     = addr;
        bus_if.data_bus_out[i*WIDTH +: WIDTH] = data;
    endtask

    task automatic bus_idle();
        for (int i = 0; i < NUM_HARTS; i++) drive_hart(i, 1'b0, '0, '0);
    endtask

    function automatic logic [WIDTH-1:0] other_addr();
        logic [WIDTH-1:0] a;
        a = $urandom();
        if (a == TOHOST) a = a ^ 32'h1;
        return a;
    endfunction

    // Bus traffic that must never count as a halt: writes elsewhere, tohost
    // reads, and (once the hart has halted) repeated tohost stores.
    task automatic drive_noise(input int i, input bit after_halt);
        case ($urandom_range(0, 2))
            0:       drive_hart(i, 1'b0, '0, '0);
            1:       drive_hart(i, 1'b1, other_addr(), $urandom());
            default: drive_hart(i, after_halt, TOHOST, $urandom());
        endcase
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_core_rst"}, 64'(core_rst), 64'd1);
        check({tag, "_running"},  64'(running),  64'd0);
        check({tag, "_done"},     64'(done),     64'd0);
        check({tag, "_timeout"},  64'(timeout),  64'd0);
        check({tag, "_halted"},   64'(halted),   64'd0);
        check({tag, "_exit"},     64'(exit_code), 64'd0);
        check({tag, "_hart_cyc"}, 64'(hart_cycles), 64'd0);
        check({tag, "_total"},    64'(total_cycles), 64'd0);
    endtask

    // One complete run. hN = RUN cycle (0-based) of hart N's first tohost
    // store, or >= MAX_CYCLES for a hart that never halts; dN = stored code.
    task automatic run_scenario(input int h0, input int h1,
                                input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        int                         h [NUM_HARTS];
        logic [WIDTH-1:0]           d [NUM_HARTS];
        bit                         all_halt;
        int                         last, exp_total, exp_done_c, first_h, c, done_c, rc;
        logic                       exp_timeout;
        logic [NUM_HARTS-1:0]       exp_halted;
        logic [WIDTH-1:0]           exp_exit;
        logic [NUM_HARTS*WIDTH-1:0] exp_hc;
        logic [WIDTH-1:0]           snap_exit, snap_total;
        logic [NUM_HARTS-1:0]       snap_halted;

        h[0] = h0; h[1] = h1;
        d[0] = d0; d[1] = d1;

        // Expected outcome from the halt times alone.
        all_halt = 1'b1;
        last     = 0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (h[i] >= MAX_CYCLES) all_halt = 1'b0;
            else if (h[i] > last)   last = h[i];
        end
        if (all_halt) begin
            exp_total   = last + 1;
            exp_timeout = 1'b0;
            exp_done_c  = last + 1 + DRAIN_CYCLES;
        end else begin
            exp_total   = MAX_CYCLES;
            exp_timeout = 1'b1;
            exp_done_c  = MAX_CYCLES;
        end
        exp_halted = '0;
        exp_exit   = '0;
        exp_hc     = '0;
        first_h    = NEVER;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (h[i] < MAX_CYCLES) begin
                exp_halted[i]           = 1'b1;
                exp_hc[i*WIDTH +: WIDTH] = WIDTH'(h[i]);
                if (h[i] < first_h) begin
                    first_h  = h[i];
                    exp_exit = d[i];
                end
            end else begin
                exp_hc[i*WIDTH +: WIDTH] = WIDTH'(MAX_CYCLES);
            end
        end

        // Start pulse, with a tohost store that must be ignored outside RUN.
        @(negedge clk);
        start = 1'b1;
        drive_hart(0, 1'b1, TOHOST, 32'hDEAD_0000);
        @(negedge clk);
        start = 1'b0;
        check("start_core_rst", 64'(core_rst), 64'd1);
        check("start_done",     64'(done),     64'd0);
        check("start_timeout",  64'(timeout),  64'd0);
        check("start_halted",   64'(halted),   64'd0);
        check("start_exit",     64'(exit_code), 64'd0);
        check("start_total",    64'(total_cycles), 64'd0);
        check("start_hart_cyc", 64'(hart_cycles), 64'd0);

        // Length of the core reset pulse.
        rc = 0;
        for (int k = 0; k < 20; k++) begin
            if (core_rst !== 1'b1) break;
            rc++;
            drive_hart(1, 1'b1, TOHOST, 32'h0000_BEEF);
            @(negedge clk);
        end
        check("reset_len",     64'(rc), 64'(RESET_CYCLES));
        check("run_running",   64'(running), 64'd1);
        check("run_total0",    64'(total_cycles), 64'd0);
        bus_idle();

        // RUN / DRAIN until done, with stray start pulses and bus noise.
        c      = 0;
        done_c = -1;
        while (c < 200) begin
            if (done === 1'b1) begin
                done_c = c;
                break;
            end
            if (c == 3) check("total_mid", 64'(total_cycles), 64'((exp_total < 3) ? exp_total : 3));
            for (int i = 0; i < NUM_HARTS; i++) begin
                if (c == h[i]) drive_hart(i, 1'b1, TOHOST, d[i]);
                else           drive_noise(i, c > h[i]);
            end
            start = (running === 1'b1) && ($urandom_range(0, 15) == 0);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        bus_idle();

        check("done_cycle", 64'(done_c),       64'(exp_done_c));
        check("timeout",    64'(timeout),      64'(exp_timeout));
        check("halted",     64'(halted),       64'(exp_halted));
        check("exit_code",  64'(exit_code),    64'(exp_exit));
        check("hart_cyc",   64'(hart_cycles),  64'(exp_hc));
        check("total",      64'(total_cycles), 64'(exp_total));
        check("done_core_rst", 64'(core_rst),  64'd1);
        check("done_running",  64'(running),   64'd0);

        // Results must hold in DONE despite further tohost stores.
        snap_exit   = exit_code;
        snap_total  = total_cycles;
        snap_halted = halted;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NUM_HARTS; i++) drive_noise(i, 1'b1);
            @(negedge clk);
        end
        bus_idle();
        check("hold_done",   64'(done), 64'd1);
        check("hold_exit",   64'(exit_code),    64'(exp_exit));
        check("hold_total",  64'(total_cycles), 64'(exp_total));
        check("hold_halted", 64'(halted),       64'(exp_halted));
        if ((snap_exit !== exit_code) || (snap_total !== total_cycles) || (snap_halted !== halted))
            check("hold_stable", 64'd1, 64'd0);
    endtask

    // Reset asserted mid-RUN, then a tohost store while IDLE.
    task automatic reset_abort();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (RESET_CYCLES) @(negedge clk);
        drive_hart(1, 1'b1, TOHOST, 32'd5);
        @(negedge clk);
        bus_idle();
        repeat (5) @(negedge clk);
        check("abort_running_before", 64'(running), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("abort");
        rst = 1'b1;
        drive_hart(0, 1'b1, TOHOST, 32'd9);
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        check("idle_store_halted", 64'(halted),    64'd0);
        check("idle_store_exit",   64'(exit_code), 64'd0);
        check("idle_running",      64'(running),   64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        bus_idle();
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst = 1'b1;
        drive_hart(0, 1'b1, TOHOST, 32'd1);
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        check("idle_halted",   64'(halted),   64'd0);
        check("idle_core_rst", 64'(core_rst), 64'd1);

        // Directed runs: staggered halts, no halt, simultaneous halts,
        // final halt on the limit edge, one cycle past it, halt on cycle 0.
        run_scenario(20, 5, 32'd9, 32'd3);
        run_scenario(NEVER, NEVER, 32'd0, 32'd0);
        run_scenario(7, 7, 32'd4, 32'd8);
        run_scenario(MAX_CYCLES - 1, 3, 32'd1, 32'd2);
        run_scenario(MAX_CYCLES, 3, 32'd1, 32'd2);
        run_scenario(10, 0, 32'd7, 32'd6);

        reset_abort();
        run_scenario(10, 10, 32'd7, 32'd8);

        // Random halt times; values at or past the limit mean no halt.
        for (int n = 0; n < 20; n++) begin
            run_scenario(int'($urandom_range(0, 55)), int'($urandom_range(0, 55)),
                         $urandom(), $urandom());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
